oled_spi_rx: RTL and testbench
==============================

OLED_SPI_RX -- requirements
Module: oled_spi_rx

Interface
REQ-001 Parameter TIMEOUT, default 1000: clk cycles without an sclk rising edge, mid-byte, before the partial byte is discarded.
REQ-002 Parameter FIFO_DEPTH, default 4: received-byte FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 sclk  input  1  serial clock from the OLED driver; idle high; asynchronous to clk.
REQ-006 sdo  input  1  serial data, MSB first; valid on the sclk rising edge.
REQ-007 dc  input  1  0 = command byte, 1 = data byte; sampled with bit 0 of each byte.
REQ-008 res  input  1  display reset, active-low; 0 holds the receiver in reset.
REQ-009 vdd  input  1  logic rail enable, active-low (0 = on).
REQ-010 vbat  input  1  panel rail enable, active-low (0 = on).
REQ-011 rx_data  output  8  byte at the FIFO head.
REQ-012 rx_dc  output  1  dc flag of the byte at the FIFO head.
REQ-013 rx_valid  output  1  FIFO not empty.
REQ-014 rx_ready  input  1  consumer accepts the head byte in a cycle where rx_valid=1 and rx_ready=1.
REQ-015 overflow  output  1  sticky: a byte was dropped because the FIFO was full.
REQ-016 frame_err  output  1  one-cycle pulse when a partial byte is discarded.
REQ-017 cmd_cnt  output  16  count of accepted command bytes; saturates at 16'hFFFF.
REQ-018 data_cnt  output  16  count of accepted data bytes; saturates at 16'hFFFF.
REQ-019 powered  output  1  registered; 1 when vdd=0 and vbat=0.

Function
REQ-020 sclk, sdo, dc and res each pass through a two-flop synchronizer; a rising edge is detected when the synchronized sclk is 1 and its previous value was 0.
REQ-021 FSM states: HOLD (synchronized res=0), IDLE (bit_cnt=0), SHIFT (bit_cnt 1..7).
REQ-022 HOLD: bit_cnt=0; FIFO flushed; timeout counter cleared; sclk edges ignored; state moves to IDLE in the first cycle after synchronized res=1.
REQ-023 On each detected edge in IDLE or SHIFT, sdo shifts into the shift register LSB and the register shifts left; bit_cnt increments modulo 8.
REQ-024 On the 8th edge, {dc, byte} is written to the FIFO in that cycle; rx_valid rises no later than one clk after the write; state returns to IDLE.
REQ-025 The byte is written to the FIFO when it is not full, or when it is full and a pop occurs in the same cycle (simultaneous push and pop both complete).
REQ-026 FIFO full with no pop: the byte is dropped, overflow is set, and neither counter changes.
REQ-027 cmd_cnt or data_cnt increments, according to dc, only on a successful FIFO write.
REQ-028 FIFO head is registered; pop when rx_valid and rx_ready; pointers wrap modulo FIFO_DEPTH; rx_data and rx_dc hold their values while rx_valid=0.
REQ-029 In SHIFT, the timeout counter clears on each edge and increments otherwise.
REQ-030 When the timeout counter reaches TIMEOUT: bit_cnt=0, the partial byte is discarded, frame_err pulses for one cycle, and state moves to IDLE.
REQ-031 No timeout in IDLE.
REQ-032 res going low mid-byte: the partial byte is discarded without a frame_err pulse; counters and overflow are kept.
REQ-033 powered is independent of res and the FSM.

Reset
REQ-034 rst=0 asynchronously clears: FSM to IDLE, bit_cnt, shift register, FIFO pointers, timeout counter, rx_data=8'h00, rx_dc=0, rx_valid=0, overflow=0, frame_err=0, cmd_cnt=0, data_cnt=0, powered=0, and all synchronizer flops (sclk synchronizer flops to 1).
REQ-035 Release of rst takes effect on the next clk edge; no sclk edge is detected in the first 2 cycles after release.

Verification
REQ-036 res=1, dc=0, byte 8'hAF sent at 1 MHz sclk, rx_ready=1 -> one rx_valid beat with rx_data=8'hAF, rx_dc=0; cmd_cnt=1; data_cnt=0.
REQ-037 rx_ready=0, 5 data bytes 8'h01..8'h05 sent (FIFO_DEPTH=4) -> FIFO holds 01..04; overflow=1; data_cnt=4; draining yields 01,02,03,04 in order.
REQ-038 3 sclk edges, then sclk held high for TIMEOUT cycles -> one frame_err pulse; next full byte 8'h3C is received intact.
REQ-039 res pulsed low for 10 cycles after 4 bits -> no frame_err; FIFO empty; next byte 8'h81 is received intact; counters unchanged across the pulse.
REQ-040 rst asserted mid-byte with 2 bytes queued -> all outputs at their reset values immediately, before the next clk edge.
REQ-041 vdd=0, then vbat=0 -> powered=1 only after both are 0; vbat=1 -> powered=0.

Source files
------------

// File: rtl/oled_spi_rx.sv
// oled_spi_rx: receive-only SPI slave for an OLED driver bus.
// Bytes arrive MSB first on sclk rising edges. Each byte is queued in a small
// FIFO together with its dc flag. Partial bytes are dropped on timeout or when
// the display reset (res) is asserted.
//
//   state | meaning
//   HOLD  | synchronized res=0; FIFO flushed, sclk ignored
//   IDLE  | waiting for the first bit of a byte (bit_cnt=0), no timeout
//   SHIFT | mid-byte (bit_cnt 1..7); timeout counter running
module oled_spi_rx #(
  parameter int TIMEOUT    = 1000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        sdo,
  input  logic        dc,
  input  logic        res,
  input  logic        vdd,
  input  logic        vbat,
  output logic [7:0]  rx_data,
  output logic        rx_dc,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        overflow,
  output logic        frame_err,
  output logic [15:0] cmd_cnt,
  output logic [15:0] data_cnt,
  output logic        powered
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_C = TW'(TIMEOUT);

  localparam logic [1:0] HOLD  = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  logic          sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic          sdo_s1_q, sdo_s2_q, dc_s1_q, dc_s2_q, res_s1_q, res_s2_q;
  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ferr_d, byte_done;
  logic [8:0]    push_word;

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_next;
  logic [AW:0]   count_q, count_d;
  logic [8:0]    head_d;
  logic          push, pop, full, flush;

  logic          sclk_rise;
  assign sclk_rise = sclk_s2_q & ~sclk_prev_q;

  // Two-flop synchronizers for every asynchronous input, plus the sclk edge history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_s1_q   <= 1'b1;
      sclk_s2_q   <= 1'b1;
      sclk_prev_q <= 1'b1;
      sdo_s1_q    <= 1'b0;
      sdo_s2_q    <= 1'b0;
      dc_s1_q     <= 1'b0;
      dc_s2_q     <= 1'b0;
      res_s1_q    <= 1'b0;
      res_s2_q    <= 1'b0;
    end else begin
      sclk_s1_q   <= sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
      sdo_s1_q    <= sdo;
      sdo_s2_q    <= sdo_s1_q;
      dc_s1_q     <= dc;
      dc_s2_q     <= dc_s1_q;
      res_s1_q    <= res;
      res_s2_q    <= res_s1_q;
    end
  end

  assign push_word = {dc_s2_q, shift_q[6:0], sdo_s2_q};

  // Receive FSM: bit shifting, byte completion and mid-byte timeout.
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tmo_d     = tmo_q;
    ferr_d    = 1'b0;
    byte_done = 1'b0;
    if (!res_s2_q) begin
      state_d = HOLD;
      bit_d   = 3'd0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        HOLD: begin
          state_d = IDLE;
          bit_d   = 3'd0;
          tmo_d   = '0;
        end
        IDLE: begin
          tmo_d = '0;
          if (sclk_rise) begin
            shift_d = {shift_q[6:0], sdo_s2_q};
            bit_d   = 3'd1;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            shift_d = {shift_q[6:0], sdo_s2_q};
            tmo_d   = '0;
            if (bit_q == 3'd7) begin
              bit_d     = 3'd0;
              state_d   = IDLE;
              byte_done = 1'b1;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else if (tmo_q == TMO_C) begin
            bit_d   = 3'd0;
            tmo_d   = '0;
            ferr_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          bit_d   = 3'd0;
          tmo_d   = '0;
        end
      endcase
    end
  end

  // FSM state, shift register, timeout counter and frame error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      tmo_q     <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
      frame_err <= ferr_d;
    end
  end

  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign flush   = ~res_s2_q;
  assign pop     = rx_valid & rx_ready;
  assign full    = (count_q == DEPTH_C);
  assign push    = byte_done & (~full | pop);
  assign rd_next = rd_ptr_q + 1'b1;

  // Next head word and occupancy.
  always_comb begin
    head_d  = {rx_dc, rx_data};
    count_d = count_q;
    if (pop) begin
      if (count_q > (AW + 1)'(1)) head_d = mem_q[rd_next];
      else if (push)              head_d = push_word;
    end else if (push && count_q == '0) begin
      head_d = push_word;
    end
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // FIFO storage; contents need no reset since occupancy gates them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  // FIFO pointers, registered head, status flags and byte counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rx_data  <= 8'h00;
      rx_dc    <= 1'b0;
      rx_valid <= 1'b0;
      overflow <= 1'b0;
      cmd_cnt  <= 16'h0000;
      data_cnt <= 16'h0000;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        rx_valid <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_next;
        count_q  <= count_d;
        rx_valid <= (count_d != '0);
        {rx_dc, rx_data} <= head_d;
      end
      if (byte_done && full && !pop) overflow <= 1'b1;
      if (push && !push_word[8] && cmd_cnt != 16'hFFFF)  cmd_cnt  <= cmd_cnt + 16'd1;
      if (push && push_word[8] && data_cnt != 16'hFFFF)  data_cnt <= data_cnt + 16'd1;
    end
  end

  // Rail status, independent of the receiver.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) powered <= 1'b0;
    else      powered <= ~vdd & ~vbat;
  end

endmodule

// File: tb/tb_oled_spi_rx.sv
// Directed bench for oled_spi_rx: bytes, overflow, timeout, res pulse, async reset, rails.
module tb_oled_spi_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b1;
  logic        sdo = 1'b0;
  logic        dc = 1'b0;
  logic        res = 1'b1;
  logic        vdd = 1'b1;
  logic        vbat = 1'b1;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_dc;
  logic        rx_valid;
  logic        overflow;
  logic        frame_err;
  logic [15:0] cmd_cnt;
  logic [15:0] data_cnt;
  logic        powered;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ferr_cnt = 0;
  logic [8:0] popq[$];

  oled_spi_rx #(.TIMEOUT(1000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sdo(sdo), .dc(dc), .res(res),
    .vdd(vdd), .vbat(vbat), .rx_data(rx_data), .rx_dc(rx_dc),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .overflow(overflow),
    .frame_err(frame_err), .cmd_cnt(cmd_cnt), .data_cnt(data_cnt),
    .powered(powered)
  );

  always #5 clk = ~clk;

  // Record accepted beats and frame error pulses, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid && rx_ready) popq.push_back({rx_dc, rx_data});
      if (frame_err) ferr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // 1 MHz sclk: 500 ns low with data set up, 500 ns high.
  task automatic send_bits(input logic [7:0] b, input logic d, input int n);
    dc = d;
    for (int i = 7; i > 7 - n; i--) begin
      sclk = 1'b0;
      sdo  = b[i];
      #500;
      sclk = 1'b1;
      #500;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst = 1'b0;
    #20;
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_overflow", overflow, 0);
    check("rst_cmd_cnt", cmd_cnt, 0);
    check("rst_data_cnt", data_cnt, 0);
    check("rst_powered", powered, 0);

    @(posedge clk); #1 rst = 1'b1;
    rx_ready = 1'b1;
    cycles(10);

    // Single command byte
    send_bits(8'hAF, 1'b0, 8);
    cycles(10);
    check("af_beats", popq.size(), 1);
    check("af_word", popq[0], {1'b0, 8'hAF});
    check("af_cmd_cnt", cmd_cnt, 1);
    check("af_data_cnt", data_cnt, 0);
    check("af_valid_low", rx_valid, 0);
    popq.delete();

    // Overflow: five data bytes into a 4-deep FIFO with no consumer
    rx_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_bits(8'(k), 1'b1, 8);
    cycles(10);
    check("ovf_flag", overflow, 1);
    check("ovf_data_cnt", data_cnt, 4);
    check("ovf_valid", rx_valid, 1);
    check("ovf_head", {rx_dc, rx_data}, {1'b1, 8'h01});
    rx_ready = 1'b1;
    cycles(10);
    check("drain_beats", popq.size(), 4);
    for (int k = 0; k < 4; k++) check("drain_word", popq[k], {1'b1, 8'(k + 1)});
    check("drain_cmd_cnt", cmd_cnt, 1);
    check("no_idle_timeout", ferr_cnt, 0);
    popq.delete();

    // Timeout after three bits
    send_bits(8'hE0, 1'b1, 3);
    cycles(800);
    check("tmo_not_early", ferr_cnt, 0);
    cycles(300);
    check("tmo_pulse", ferr_cnt, 1);
    check("tmo_no_beat", popq.size(), 0);
    send_bits(8'h3C, 1'b1, 8);
    cycles(10);
    check("tmo_next_beats", popq.size(), 1);
    check("tmo_next_word", popq[0], {1'b1, 8'h3C});
    check("tmo_data_cnt", data_cnt, 5);
    popq.delete();

    // res pulse after four bits
    send_bits(8'h55, 1'b0, 4);
    res = 1'b0;
    cycles(10);
    res = 1'b1;
    cycles(1100);
    check("res_no_ferr", ferr_cnt, 1);
    check("res_fifo_empty", rx_valid, 0);
    check("res_cmd_cnt", cmd_cnt, 1);
    check("res_data_cnt", data_cnt, 5);
    check("res_overflow_kept", overflow, 1);
    send_bits(8'h81, 1'b0, 8);
    cycles(10);
    check("res_next_beats", popq.size(), 1);
    check("res_next_word", popq[0], {1'b0, 8'h81});
    check("res_next_cmd_cnt", cmd_cnt, 2);
    popq.delete();

    // Async reset mid-byte with two bytes queued
    rx_ready = 1'b0;
    send_bits(8'h11, 1'b1, 8);
    send_bits(8'h22, 1'b1, 8);
    send_bits(8'hF0, 1'b1, 3);
    cycles(5);
    check("pre_rst_head", rx_data, 8'h11);
    @(negedge clk); #1 rst = 1'b0;
    #1;
    check("arst_rx_valid", rx_valid, 0);
    check("arst_rx_data", rx_data, 8'h00);
    check("arst_rx_dc", rx_dc, 0);
    check("arst_overflow", overflow, 0);
    check("arst_cmd_cnt", cmd_cnt, 0);
    check("arst_data_cnt", data_cnt, 0);
    check("arst_frame_err", frame_err, 0);
    @(posedge clk); #1 rst = 1'b1;
    cycles(5);

    // Rails
    vdd = 1'b0;
    cycles(3);
    check("pwr_vdd_only", powered, 0);
    vbat = 1'b0;
    cycles(3);
    check("pwr_both", powered, 1);
    vbat = 1'b1;
    cycles(3);
    check("pwr_vbat_off", powered, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
